// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arb_pkg
//  Purpose  : Shared types, constants and helpers for the data-memory arbiter.
//             - state_t     : arbiter FSM state encoding
//             - WSTRB_FULL  : byte-enable pattern of a full-word store
//             - merge_bytes : per-byte merge used by read-modify-write
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RD_WAIT  = 3'd2,
        WR       = 3'd3,
        RMW_RD   = 3'd4,
        RMW_WAIT = 3'd5,
        RMW_WR   = 3'd6,
        RESP     = 3'd7
    } state_t;

    localparam logic [3:0] WSTRB_FULL = 4'hF;

    // Byte k of the result comes from new_word when strb[k] is set,
    // otherwise it keeps the byte already held in memory.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter with an internal rotating priority pointer.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             req[N]        - request vector
//             advance       - a grant was taken this cycle; rotate pointer
//             grant[N]      - one-hot winner (zero when no request)
//             idx           - binary index of the winner
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;

    // Search upward from the pointer with wrap-around; first hit wins.
    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Shares one word-addressed DataMemory between NREQ requesters.
//             Round-robin grant, byte-to-word address conversion with range
//             check, read-modify-write for partial stores, one response
//             pulse per accepted request.
//  Ports    : ACLK, ARESET          - clock, synchronous active-high reset
//             REQ_VALID/READY       - per-requester request handshake
//             REQ_WE/ADDR/WSTRB/WDATA - per-requester request payload
//             RSP_VALID/RDATA/ERR   - one-cycle response to the owner
//             MEM_RDSTB/WRSTB/ADDR/WDATA/RDATA - DataMemory interface
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          NREQ        = 2,
    parameter int          DMSIZE      = 1024,
    parameter logic [31:0] BASEADDRESS = 32'h0000_0000
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NREQ-1:0]             REQ_VALID,
    output logic [NREQ-1:0]             REQ_READY,
    input  logic [NREQ-1:0]             REQ_WE,
    input  logic [NREQ-1:0][31:0]       REQ_ADDR,
    input  logic [NREQ-1:0][3:0]        REQ_WSTRB,
    input  logic [NREQ-1:0][31:0]       REQ_WDATA,
    output logic [NREQ-1:0]             RSP_VALID,
    output logic [31:0]                 RSP_RDATA,
    output logic                        RSP_ERR,
    output logic                        MEM_RDSTB,
    output logic                        MEM_WRSTB,
    output logic [31:0]                 MEM_ADDR,
    output logic [31:0]                 MEM_WDATA,
    input  logic [31:0]                 MEM_RDATA
);

    localparam int IW = $clog2(NREQ);

    state_t        state_q,     state_d;
    logic [IW-1:0] owner_q,     owner_d;
    logic [3:0]    strb_q,      strb_d;
    logic [31:0]   wdata_q,     wdata_d;
    logic [31:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q,   rsp_err_d;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_idx;
    logic            w_accept;
    logic [31:0]     w_word_addr;
    logic            w_legal;
    logic [3:0]      w_strb;

    // Acceptance only in IDLE; reset masks READY so no handshake is
    // reported for a cycle that the reset is about to discard.
    assign w_accept = (state_q == IDLE) && (|REQ_VALID) && !ARESET;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk     (ACLK),
        .rst     (ARESET),
        .req     (REQ_VALID),
        .advance (w_accept),
        .grant   (w_grant),
        .idx     (w_idx)
    );

    assign REQ_READY   = w_accept ? w_grant : '0;
    assign w_word_addr = REQ_ADDR[w_idx] >> 2;
    assign w_strb      = REQ_WSTRB[w_idx];

    // 33-bit compare so BASEADDRESS+DMSIZE cannot wrap.
    assign w_legal = ({1'b0, w_word_addr} >= {1'b0, BASEADDRESS}) &&
                     ({1'b0, w_word_addr} <  ({1'b0, BASEADDRESS} + 33'(DMSIZE)));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        strb_d      = strb_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    owner_d     = w_idx;
                    strb_d      = w_strb;
                    wdata_d     = REQ_WDATA[w_idx];
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (!w_legal) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else if (!REQ_WE[w_idx]) begin
                        mem_addr_d = w_word_addr;
                        state_d    = RD;
                    end else if (w_strb == WSTRB_FULL) begin
                        mem_addr_d  = w_word_addr;
                        mem_wdata_d = REQ_WDATA[w_idx];
                        state_d     = WR;
                    end else if (w_strb == 4'h0) begin
                        state_d = RESP;
                    end else begin
                        mem_addr_d = w_word_addr;
                        state_d    = RMW_RD;
                    end
                end
            end
            RD:       state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_rdata_d = MEM_RDATA;
                state_d     = RESP;
            end
            WR:       state_d = RESP;
            RMW_RD:   state_d = RMW_WAIT;
            RMW_WAIT: begin
                mem_wdata_d = merge_bytes(MEM_RDATA, wdata_q, strb_q);
                state_d     = RMW_WR;
            end
            RMW_WR:   state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            strb_q      <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            strb_q      <= strb_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Strobes and response are pure decodes of the state register; the
    // read and write state sets are disjoint so the strobes never overlap.
    assign MEM_RDSTB = (state_q == RD) || (state_q == RMW_RD);
    assign MEM_WRSTB = (state_q == WR) || (state_q == RMW_WR);
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;

    always_comb begin
        RSP_VALID = '0;
        if (state_q == RESP) begin
            RSP_VALID[owner_q] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter with a
//             behavioural DataMemory (registered read, word write).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int          NREQ   = 2;
    localparam int          DMSIZE = 1024;
    localparam logic [31:0] BASE   = 32'h0;

    logic                  ACLK = 1'b0;
    logic                  ARESET;
    logic [NREQ-1:0]       REQ_VALID, REQ_READY, REQ_WE, RSP_VALID;
    logic [NREQ-1:0][31:0] REQ_ADDR, REQ_WDATA;
    logic [NREQ-1:0][3:0]  REQ_WSTRB;
    logic [31:0]           RSP_RDATA, MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic                  RSP_ERR, MEM_RDSTB, MEM_WRSTB;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(
        .NREQ(NREQ), .DMSIZE(DMSIZE), .BASEADDRESS(BASE)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_WSTRB(REQ_WSTRB), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .MEM_RDSTB(MEM_RDSTB), .MEM_WRSTB(MEM_WRSTB), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc++;

    // DataMemory model: read data valid only the cycle after RDSTB,
    // garbage otherwise so mistimed sampling is visible.
    logic [31:0] mem [0:DMSIZE-1];
    logic [31:0] mem_rd_q;
    logic        mem_rd_vld;
    always @(posedge ACLK) begin
        if (MEM_WRSTB) mem[MEM_ADDR[9:0]] <= MEM_WDATA;
        mem_rd_q   <= mem[MEM_ADDR[9:0]];
        mem_rd_vld <= MEM_RDSTB;
    end
    assign MEM_RDATA = mem_rd_vld ? mem_rd_q : 32'hBADC_0DE5;

    // Bus monitor.
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0, rsp_cnt = 0;
    int          rd_cyc = -1, wr_cyc = -1;
    logic [31:0] rd_addr, wr_addr, wr_data;
    always @(negedge ACLK) begin
        if (MEM_RDSTB) begin rd_cnt++; rd_cyc = cyc; rd_addr = MEM_ADDR; end
        if (MEM_WRSTB) begin wr_cnt++; wr_cyc = cyc; wr_addr = MEM_ADDR; wr_data = MEM_WDATA; end
        if (MEM_RDSTB && MEM_WRSTB) both_cnt++;
        if (|RSP_VALID) rsp_cnt++;
    end

    // Drive one request, wait for READY then for the response (bounded).
    task automatic do_txn(input int r, input logic we, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wdata,
                          output int t_acc, output int t_rsp,
                          output logic [31:0] rdata, output logic err,
                          output logic [NREQ-1:0] rspv);
        t_acc = -1; t_rsp = -100; rdata = 'x; err = 'x; rspv = '0;
        @(posedge ACLK); #1;
        REQ_VALID[r] = 1'b1; REQ_WE[r] = we; REQ_ADDR[r] = addr;
        REQ_WSTRB[r] = strb; REQ_WDATA[r] = wdata;
        for (int i = 0; i < 20 && t_acc < 0; i++) begin
            @(negedge ACLK);
            if (REQ_READY[r]) t_acc = cyc;
        end
        @(posedge ACLK); #1;
        REQ_VALID[r] = 1'b0;
        for (int i = 0; i < 20 && t_rsp < 0; i++) begin
            if (i > 0) @(negedge ACLK);
            else @(negedge ACLK);
            if (|RSP_VALID) begin
                t_rsp = cyc; rdata = RSP_RDATA; err = RSP_ERR; rspv = RSP_VALID;
            end
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1; REQ_VALID = '0; REQ_WE = '0; REQ_ADDR = '0;
        REQ_WSTRB = '0; REQ_WDATA = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        n_checks++; if (REQ_READY !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", REQ_READY); end
        n_checks++; if (RSP_VALID !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 00", RSP_VALID); end
        n_checks++; if ({MEM_RDSTB, MEM_WRSTB} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {MEM_RDSTB, MEM_WRSTB}); end
        n_checks++; if ({RSP_RDATA, RSP_ERR} !== 33'h0) begin n_fail++; $display("FAIL reset_rsp got %h/%b want 0/0", RSP_RDATA, RSP_ERR); end
        n_checks++; if ({MEM_ADDR, MEM_WDATA} !== 64'h0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0/0", MEM_ADDR, MEM_WDATA); end
        @(posedge ACLK); #1;
        ARESET = 1'b0;
    endtask

    task automatic test_load();
        int ta, tr; logic [31:0] d; logic e; logic [NREQ-1:0] v;
        do_txn(0, 1'b0, 32'h14, 4'h0, 32'h0, ta, tr, d, e, v);
        n_checks++; if (tr - ta !== 3) begin n_fail++; $display("FAIL load_latency got %0d want 3", tr - ta); end
        n_checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL load_data got %h err %b want deadbeef err 0", d, e); end
        n_checks++; if (v !== 2'b01) begin n_fail++; $display("FAIL load_owner got %b want 01", v); end
        n_checks++; if (rd_addr !== 32'd5 || rd_cyc !== ta + 1) begin n_fail++; $display("FAIL load_rdstb got addr %0d cyc %0d want 5 %0d", rd_addr, rd_cyc, ta + 1); end
    endtask

    task automatic test_partial_store();
        int ta, tr; logic [31:0] d; logic e; logic [NREQ-1:0] v;
        do_txn(0, 1'b1, 32'h08, 4'b0100, 32'h00AA0000, ta, tr, d, e, v);
        n_checks++; if (rd_cyc !== ta + 1) begin n_fail++; $display("FAIL rmw_rdstb_cyc got %0d want %0d", rd_cyc, ta + 1); end
        n_checks++; if (wr_cyc !== ta + 3) begin n_fail++; $display("FAIL rmw_wrstb_cyc got %0d want %0d", wr_cyc, ta + 3); end
        n_checks++; if (wr_data !== 32'h11AA3344 || wr_addr !== 32'd2) begin n_fail++; $display("FAIL rmw_wdata got %h@%0d want 11aa3344@2", wr_data, wr_addr); end
        n_checks++; if (mem[2] !== 32'h11AA3344) begin n_fail++; $display("FAIL rmw_mem got %h want 11aa3344", mem[2]); end
        n_checks++; if (tr - ta !== 4 || e !== 1'b0) begin n_fail++; $display("FAIL rmw_resp got lat %0d err %b want 4 0", tr - ta, e); end
    endtask

    task automatic test_full_store_load();
        int ta, tr; logic [31:0] d; logic e; logic [NREQ-1:0] v;
        do_txn(1, 1'b1, 32'h1C, 4'hF, 32'hCAFEF00D, ta, tr, d, e, v);
        n_checks++; if (tr - ta !== 2 || v !== 2'b10) begin n_fail++; $display("FAIL store_resp got lat %0d owner %b want 2 10", tr - ta, v); end
        n_checks++; if (mem[7] !== 32'hCAFEF00D || wr_cyc !== ta + 1) begin n_fail++; $display("FAIL store_mem got %h cyc %0d want cafef00d %0d", mem[7], wr_cyc, ta + 1); end
        do_txn(1, 1'b0, 32'h1C, 4'h0, 32'h0, ta, tr, d, e, v);
        n_checks++; if (d !== 32'hCAFEF00D || tr - ta !== 3) begin n_fail++; $display("FAIL store_readback got %h lat %0d want cafef00d 3", d, tr - ta); end
    endtask

    task automatic test_out_of_range();
        int ta, tr, rc, wc; logic [31:0] d; logic e; logic [NREQ-1:0] v;
        rc = rd_cnt; wc = wr_cnt;
        do_txn(0, 1'b1, 32'(4 * DMSIZE), 4'hF, 32'h12345678, ta, tr, d, e, v);
        n_checks++; if (tr - ta !== 1 || e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL oor_resp got lat %0d err %b data %h want 1 1 0", tr - ta, e, d); end
        n_checks++; if (rd_cnt !== rc || wr_cnt !== wc) begin n_fail++; $display("FAIL oor_strobe got rd %0d wr %0d want %0d %0d", rd_cnt, wr_cnt, rc, wc); end
        do_txn(0, 1'b0, 32'h14, 4'h0, 32'h0, ta, tr, d, e, v);
        n_checks++; if (e !== 1'b0 || d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_followup got %h err %b want deadbeef 0", d, e); end
    endtask

    task automatic test_empty_store();
        int ta, tr, rc, wc; logic [31:0] d; logic e; logic [NREQ-1:0] v;
        rc = rd_cnt; wc = wr_cnt;
        do_txn(1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, ta, tr, d, e, v);
        n_checks++; if (tr - ta !== 1 || e !== 1'b0 || rd_cnt !== rc || wr_cnt !== wc) begin
            n_fail++; $display("FAIL empty_store got lat %0d err %b rd %0d wr %0d want 1 0 %0d %0d", tr - ta, e, rd_cnt, wr_cnt, rc, wc);
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] g [4];
        int gc [4];
        int n;
        n = 0;
        ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1; ARESET = 1'b0;
        REQ_VALID = 2'b11; REQ_WE = 2'b00;
        REQ_ADDR[0] = 32'h14; REQ_ADDR[1] = 32'h1C;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge ACLK);
            if (REQ_READY !== 2'b00) begin g[n] = REQ_READY; gc[n] = cyc; n++; end
        end
        @(posedge ACLK); #1;
        REQ_VALID = 2'b00;
        repeat (6) @(posedge ACLK);
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL contention_count got %0d want 4", n); end
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (g[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL contention_grant%0d got %b want %b", k, g[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        if (n > 1) begin
            n_checks++; if (gc[1] - gc[0] !== 4) begin n_fail++; $display("FAIL contention_spacing got %0d want 4", gc[1] - gc[0]); end
        end
    endtask

    task automatic test_reset_mid_rmw();
        int wc, rspc, ta;
        ta = -1;
        @(posedge ACLK); #1;
        REQ_VALID[0] = 1'b1; REQ_WE[0] = 1'b1; REQ_ADDR[0] = 32'h24;
        REQ_WSTRB[0] = 4'b0001; REQ_WDATA[0] = 32'h000000FF;
        for (int i = 0; i < 20 && ta < 0; i++) begin
            @(negedge ACLK);
            if (REQ_READY[0]) ta = cyc;
        end
        wc = wr_cnt; rspc = rsp_cnt;
        @(posedge ACLK); #1;               // RMW_RD
        REQ_VALID = 2'b00;
        @(posedge ACLK); #1;               // RMW_WAIT
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        n_checks++; if ({MEM_RDSTB, MEM_WRSTB, RSP_VALID} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_rmw_post_reset got strobes %b%b rsp %b want 0", MEM_RDSTB, MEM_WRSTB, RSP_VALID);
        end
        repeat (5) @(negedge ACLK);
        n_checks++; if (wr_cnt !== wc || rsp_cnt !== rspc) begin n_fail++; $display("FAIL mid_rmw_abort got wr %0d rsp %0d want %0d %0d", wr_cnt, rsp_cnt, wc, rspc); end
        n_checks++; if (mem[9] !== 32'h55667788) begin n_fail++; $display("FAIL mid_rmw_mem got %h want 55667788", mem[9]); end
        @(posedge ACLK); #1;
        REQ_VALID = 2'b11; REQ_WE = 2'b00; REQ_ADDR[0] = 32'h14; REQ_ADDR[1] = 32'h14;
        @(negedge ACLK);
        n_checks++; if (REQ_READY !== 2'b01) begin n_fail++; $display("FAIL mid_rmw_pointer got %b want 01", REQ_READY); end
        @(posedge ACLK); #1;
        REQ_VALID = 2'b00;
        repeat (6) @(posedge ACLK);
    endtask

    initial begin
        mem[2] <= 32'h11223344;
        mem[5] <= 32'hDEADBEEF;
        mem[7] <= 32'h0;
        mem[9] <= 32'h55667788;
        test_reset();
        test_load();
        test_partial_store();
        test_full_store_load();
        test_out_of_range();
        test_empty_store();
        test_contention();
        test_reset_mid_rmw();
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_exclusive got %0d overlaps want 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
